mips_bus_lsu: RTL and testbench

MIPS_BUS_LSU -- requirements
Module: mips_bus_lsu

---
 rtl/mips_bus_lsu.sv | 187 ++++++++++++++++++
 tb/tb_mips_bus_lsu.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_lsu.sv
// MIPS load/store unit driving a single Avalon-MM master port.
// One request in flight: accept in IDLE, transfer in BUS, one-cycle pulse in RESP.
module mips_bus_lsu #(
  parameter int ADDR_W     = 32,
  parameter int WAIT_LIMIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_rt_old,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  input  logic              waitrequest,
  output logic [31:0]       writedata,
  output logic [3:0]        byteenable,
  input  logic [31:0]       readdata
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [3:0] OP_LW = 4'd0, OP_LH = 4'd1, OP_LHU = 4'd2, OP_LB = 4'd3,
                         OP_LBU = 4'd4, OP_LWL = 4'd5, OP_LWR = 4'd6, OP_SW = 4'd7,
                         OP_SH = 4'd8, OP_SB = 4'd9;

  state_t            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [1:0]        k_q, k_d;
  logic [31:0]       rt_old_q, rt_old_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic              read_q, read_d, write_q, write_d;
  logic [31:0]       writedata_q, writedata_d;
  logic [3:0]        byteenable_q, byteenable_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic [31:0]       resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;

  logic              req_bad;
  logic [3:0]        req_be;
  logic [31:0]       req_wd;
  logic [31:0]       load_data;
  logic [31:0]       lane;
  logic [4:0]        sh;

  // Request decode: legality/alignment plus lane enables and replicated store data.
  always_comb begin
    req_bad = 1'b0;
    req_be  = 4'b1111;
    req_wd  = req_wdata;
    case (req_op)
      OP_LW, OP_SW:          req_bad = (req_addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: begin
        req_bad = req_addr[0];
        req_be  = 4'b0011 << req_addr[1:0];
        req_wd  = {2{req_wdata[15:0]}};
      end
      OP_LB, OP_LBU, OP_SB: begin
        req_be  = 4'b0001 << req_addr[1:0];
        req_wd  = {4{req_wdata[7:0]}};
      end
      OP_LWL, OP_LWR:        req_bad = 1'b0;
      default:               req_bad = 1'b1;
    endcase
  end

  // Load extraction and LWL/LWR merge against the old rt value.
  always_comb begin
    sh        = {k_q, 3'b000};
    lane      = readdata >> sh;
    load_data = readdata;
    case (op_q)
      OP_LH:   load_data = {{16{lane[15]}}, lane[15:0]};
      OP_LHU:  load_data = {16'h0000, lane[15:0]};
      OP_LB:   load_data = {{24{lane[7]}}, lane[7:0]};
      OP_LBU:  load_data = {24'h000000, lane[7:0]};
      OP_LWL:  load_data = (readdata << (5'd24 - sh)) |
                           (rt_old_q & (32'hFFFF_FFFF >> ({1'b0, sh} + 6'd8)));
      OP_LWR:  load_data = (readdata >> sh) | (rt_old_q & ~(32'hFFFF_FFFF >> sh));
      default: load_data = readdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    k_d          = k_q;
    rt_old_d     = rt_old_q;
    address_d    = address_q;
    read_d       = read_q;
    write_d      = write_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    wait_cnt_d   = wait_cnt_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d     = req_op;
          k_d      = req_addr[1:0];
          rt_old_d = req_rt_old;
          if (req_bad) begin
            state_d     = RESP;
            resp_err_d  = 1'b1;
            resp_data_d = 32'h0;
          end else begin
            state_d      = BUS;
            address_d    = {req_addr[ADDR_W-1:2], 2'b00};
            read_d       = (req_op <= OP_LWR);
            write_d      = (req_op >= OP_SW);
            writedata_d  = req_wd;
            byteenable_d = req_be;
            wait_cnt_d   = 8'd0;
          end
        end
      end
      BUS: begin
        if (waitrequest) begin
          // The WAIT_LIMIT-th stalled cycle ends the attempt.
          if (wait_cnt_q == 8'(WAIT_LIMIT - 1)) begin
            state_d     = RESP;
            read_d      = 1'b0;
            write_d     = 1'b0;
            resp_err_d  = 1'b1;
            resp_data_d = 32'h0;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end else begin
          state_d     = RESP;
          read_d      = 1'b0;
          write_d     = 1'b0;
          resp_err_d  = 1'b0;
          resp_data_d = write_q ? 32'h0 : load_data;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      op_q         <= 4'd0;
      k_q          <= 2'd0;
      rt_old_q     <= 32'h0;
      address_q    <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      writedata_q  <= 32'h0;
      byteenable_q <= 4'h0;
      wait_cnt_q   <= 8'd0;
      resp_data_q  <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      k_q          <= k_d;
      rt_old_q     <= rt_old_d;
      address_q    <= address_d;
      read_q       <= read_d;
      write_q      <= write_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      wait_cnt_q   <= wait_cnt_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;
endmodule

// File: tb/tb_mips_bus_lsu.sv
// Directed bench for mips_bus_lsu: expected responses are queued at issue time
// and compared by a monitor whenever resp_valid pulses.
module tb_mips_bus_lsu;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr, req_wdata, req_rt_old;
  logic        resp_valid, resp_err;
  logic [31:0] resp_data;
  logic [31:0] address;
  logic        read, write, waitrequest;
  logic [31:0] writedata, readdata;
  logic [3:0]  byteenable;

  always #5 clk = ~clk;

  mips_bus_lsu #(.ADDR_W(32), .WAIT_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rt_old(req_rt_old),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .address(address), .read(read), .write(write), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_resp   = 0;
  int n_exp    = 0;
  logic [32:0] exp_q[$];

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr, wd, rt, rd;
    logic [3:0]  be;
    logic [31:0] wdx, data;
  } vec_t;

  vec_t vecs [0:12] = '{
    '{4'd6, 32'h11,  32'h0,        32'h11223344, 32'hAABBCCDD, 4'hF, 32'h0,        32'h11AABBCC},
    '{4'd5, 32'h11,  32'h0,        32'h11223344, 32'hAABBCCDD, 4'hF, 32'h0,        32'hCCDD3344},
    '{4'd5, 32'h13,  32'h0,        32'h11223344, 32'hAABBCCDD, 4'hF, 32'h0,        32'hAABBCCDD},
    '{4'd6, 32'h13,  32'h0,        32'h11223344, 32'hAABBCCDD, 4'hF, 32'h0,        32'h112233AA},
    '{4'd0, 32'h100, 32'h0,        32'h0,        32'h80011234, 4'hF, 32'h0,        32'h80011234},
    '{4'd1, 32'h102, 32'h0,        32'h0,        32'h80011234, 4'hC, 32'h0,        32'hFFFF8001},
    '{4'd2, 32'h102, 32'h0,        32'h0,        32'h80011234, 4'hC, 32'h0,        32'h00008001},
    '{4'd1, 32'h100, 32'h0,        32'h0,        32'h80011234, 4'h3, 32'h0,        32'h00001234},
    '{4'd4, 32'h101, 32'h0,        32'h0,        32'h80FFFF11, 4'h2, 32'h0,        32'h000000FF},
    '{4'd3, 32'h100, 32'h0,        32'h0,        32'h80FFFF11, 4'h1, 32'h0,        32'h00000011},
    '{4'd7, 32'h20,  32'hDEADBEEF, 32'h0,        32'hFFFFFFFF, 4'hF, 32'hDEADBEEF, 32'h0},
    '{4'd9, 32'h21,  32'h12345678, 32'h0,        32'hFFFFFFFF, 4'h2, 32'h78787878, 32'h0},
    '{4'd8, 32'h20,  32'h1234ABCD, 32'h0,        32'hFFFFFFFF, 4'h3, 32'hABCDABCD, 32'h0}
  };

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the next rising edge is the accept edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rt, input logic [31:0] ed, input logic ee,
                       input bit push);
    req_valid  = 1'b1;
    req_op     = op;
    req_addr   = addr;
    req_wdata  = wd;
    req_rt_old = rt;
    if (push) begin
      exp_q.push_back({ee, ed});
      n_exp++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    $display("issue op=%0d addr=0x%08h wdata=0x%08h rt_old=0x%08h", op, addr, wd, rt);
  endtask

  task automatic xfer(input vec_t v);
    readdata    = v.rd;
    waitrequest = 1'b0;
    issue(v.op, v.addr, v.wd, v.rt, v.data, 1'b0, 1'b1);
    chk($sformatf("op%0d_read", v.op), 32'(read), (v.op <= 4'd6) ? 32'd1 : 32'd0);
    chk($sformatf("op%0d_write", v.op), 32'(write), (v.op >= 4'd7) ? 32'd1 : 32'd0);
    chk($sformatf("op%0d_be", v.op), 32'(byteenable), 32'(v.be));
    chk($sformatf("op%0d_addr", v.op), address, {v.addr[31:2], 2'b00});
    if (v.op >= 4'd7) chk($sformatf("op%0d_wdata", v.op), writedata, v.wdx);
    @(negedge clk);
    chk($sformatf("op%0d_resp_valid", v.op), 32'(resp_valid), 32'd1);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      n_resp++;
      if (exp_q.size() == 0) begin
        chk("resp_unexpected_pending", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("resp_data", resp_data, e[31:0]);
        chk("resp_err", 32'(resp_err), 32'(e[32]));
        $display("resp data=0x%08h err=%0d (expected 0x%08h err=%0d)",
                 resp_data, resp_err, e[31:0], e[32]);
      end
    end
  end

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_addr = 32'h0;
    req_wdata = 32'h0; req_rt_old = 32'h0; waitrequest = 1'b0; readdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_read", 32'(read), 32'd0);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_address", address, 32'h0);
    chk("rst_be", 32'(byteenable), 32'd0);
    chk("rst_wdata", writedata, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);

    // LB at the top lane: sign-extended 0x80, response two cycles after accept.
    readdata = 32'h80FF_FF11;
    issue(4'd3, 32'h1003, 32'h0, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b1);
    chk("lb_read", 32'(read), 32'd1);
    chk("lb_write", 32'(write), 32'd0);
    chk("lb_be", 32'(byteenable), 32'h8);
    chk("lb_addr", address, 32'h1000);
    chk("lb_busy", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("lb_resp_valid", 32'(resp_valid), 32'd1);
    chk("lb_read_off", 32'(read), 32'd0);
    @(negedge clk);
    chk("lb_ready_again", 32'(req_ready), 32'd1);
    chk("lb_pulse_once", 32'(resp_valid), 32'd0);
    chk("lb_hold", resp_data, 32'hFFFF_FF80);

    // Misaligned LW: no bus cycle, error response at t+1.
    issue(4'd0, 32'h6, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    chk("lwmis_read", 32'(read), 32'd0);
    chk("lwmis_write", 32'(write), 32'd0);
    chk("lwmis_resp_valid", 32'(resp_valid), 32'd1);
    @(negedge clk);
    chk("lwmis_ready", 32'(req_ready), 32'd1);

    // SH with three wait cycles: write held for four cycles.
    waitrequest = 1'b1;
    issue(4'd8, 32'h2002, 32'h1234_ABCD, 32'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sh_write_c%0d", i), 32'(write), 32'd1);
      chk($sformatf("sh_read_c%0d", i), 32'(read), 32'd0);
      chk($sformatf("sh_be_c%0d", i), 32'(byteenable), 32'hC);
      chk($sformatf("sh_wdata_c%0d", i), writedata, 32'hABCD_ABCD);
      chk($sformatf("sh_addr_c%0d", i), address, 32'h2000);
      chk($sformatf("sh_novalid_c%0d", i), 32'(resp_valid), 32'd0);
      if (i == 3) waitrequest = 1'b0;
      @(negedge clk);
    end
    chk("sh_resp_valid", 32'(resp_valid), 32'd1);
    chk("sh_write_off", 32'(write), 32'd0);
    @(negedge clk);
    chk("sh_pulse_once", 32'(resp_valid), 32'd0);

    for (int i = 0; i < 13; i++) xfer(vecs[i]);

    // Illegal op and misaligned SH both error without a bus cycle.
    issue(4'd12, 32'h40, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    chk("illegal_read", 32'(read), 32'd0);
    chk("illegal_resp_valid", 32'(resp_valid), 32'd1);
    @(negedge clk);
    issue(4'd8, 32'h201, 32'h5555, 32'h0, 32'h0, 1'b1, 1'b1);
    chk("shmis_write", 32'(write), 32'd0);
    chk("shmis_resp_valid", 32'(resp_valid), 32'd1);
    @(negedge clk);

    // Timeout after four stalled cycles, then a clean LW.
    waitrequest = 1'b1;
    issue(4'd0, 32'h40, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_read_c%0d", i), 32'(read), 32'd1);
      @(negedge clk);
    end
    chk("to_read_off", 32'(read), 32'd0);
    chk("to_resp_valid", 32'(resp_valid), 32'd1);
    chk("to_resp_err", 32'(resp_err), 32'd1);
    @(negedge clk);
    begin
      vec_t v;
      v = '{4'd0, 32'h44, 32'h0, 32'h0, 32'hCAFE_F00D, 4'hF, 32'h0, 32'hCAFE_F00D};
      xfer(v);
    end
    chk("after_to_err", 32'(resp_err), 32'd0);

    // Reset during a stalled read abandons the transfer.
    waitrequest = 1'b1;
    issue(4'd0, 32'h80, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("rstmid_read_before", 32'(read), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rstmid_read", 32'(read), 32'd0);
    chk("rstmid_address", address, 32'h0);
    chk("rstmid_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    waitrequest = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rstmid_novalid_c%0d", i), 32'(resp_valid), 32'd0);
      chk($sformatf("rstmid_ready_c%0d", i), 32'(req_ready), 32'd1);
    end

    chk("resp_count", 32'(n_resp), 32'(n_exp));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
